// File: rtl/l6_ctrl_pkg.sv
// Shared constants for the Lab 6 step controller.
//   - control FSM state encoding (2 bits)
//   - default parameter values used by l6_step_ctrl and key_debounce
package l6_ctrl_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int DEB_CYCLES_DEF = 16;
   localparam int RATE_W_DEF     = 24;
   localparam int PAT_W_DEF      = 16;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, falling-edge detect.
// Ports:
//   clk    system clock
//   rst    asynchronous active-low reset
//   key_n  raw pushbutton, low = pressed, asynchronous to clk
//   level  debounced key level (1 = released)
//   press  one-cycle pulse on a debounced 1->0 transition
module key_debounce
   import l6_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The level only flips once the counter has already reached DEB_CYCLES and the
   // sample still disagrees, so a bounce shorter than DEB_CYCLES cycles never lands.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEB_CYCLES)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_q & ~level_d;
   end

   // Synchronizer resets to "released" so reset release never looks like a press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/l6_step_ctrl.sv
// Step controller for the Lab 6 sequence-detector FSM. Produces single-cycle step
// enables from a debounced key (manual) or an auto-run divider, and supplies w
// either live from w_in or from a preloaded playback pattern.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   key_n    raw pushbutton, low = pressed
//   run      0 = manual (key), 1 = auto (timer)
//   rate     auto period minus one, in clk cycles
//   load     pattern load strobe
//   pattern  playback bits, bit 0 played first
//   w_in     live w source used in S_IDLE
//   step     one-cycle FSM enable (registered)
//   w        FSM input, valid with step (registered, holds otherwise)
//   pos      number of pattern bits already played
//   done     pattern exhausted
//
// state  | meaning
// S_IDLE | live stepping, w taken from w_in
// S_RUN  | playback, w taken from shift register bit 0
// S_DONE | pattern exhausted, steps suppressed until press or load
module l6_step_ctrl
   import l6_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int RATE_W     = RATE_W_DEF,
   parameter int PAT_W      = PAT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       key_n,
   input  logic                       run,
   input  logic [RATE_W-1:0]          rate,
   input  logic                       load,
   input  logic [PAT_W-1:0]           pattern,
   input  logic                       w_in,
   output logic                       step,
   output logic                       w,
   output logic [$clog2(PAT_W+1)-1:0] pos,
   output logic                       done
);

   localparam int POS_W = $clog2(PAT_W + 1);

   logic              key_level;
   logic              press;
   logic              tick;
   logic              trig;

   logic [RATE_W-1:0] div_q, div_d;
   logic [1:0]        state_q, state_d;
   logic [PAT_W-1:0]  shreg_q, shreg_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic              step_q, step_d;
   logic              w_q, w_d;

   key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key_debounce (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n),
      .level (key_level),
      .press (press)
   );

   // Plain increment with natural wrap: if rate drops below the current count the
   // divider runs up to all-ones and wraps before it can match again.
   always_comb begin
      tick  = run && (div_q == rate);
      div_d = '0;
      if (run && !tick) begin
         div_d = div_q + 1'b1;
      end
   end

   assign trig = run ? tick : press;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      pos_d   = pos_q;
      step_d  = 1'b0;
      w_d     = w_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               shreg_d = pattern;
               pos_d   = '0;
               state_d = S_RUN;
            end else if (trig) begin
               step_d = 1'b1;
               w_d    = w_in;
            end
         end
         S_RUN: begin
            if (load) begin
               shreg_d = pattern;
               pos_d   = '0;
            end else if (trig) begin
               step_d  = 1'b1;
               w_d     = shreg_q[0];
               shreg_d = shreg_q >> 1;
               pos_d   = pos_q + 1'b1;
               if (pos_q + 1'b1 == POS_W'(PAT_W)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (load) begin
               shreg_d = pattern;
               pos_d   = '0;
               state_d = S_RUN;
            end else if (press && !run) begin
               pos_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q   <= '0;
         state_q <= S_IDLE;
         shreg_q <= '0;
         pos_q   <= '0;
         step_q  <= 1'b0;
         w_q     <= 1'b0;
      end else begin
         div_q   <= div_d;
         state_q <= state_d;
         shreg_q <= shreg_d;
         pos_q   <= pos_d;
         step_q  <= step_d;
         w_q     <= w_d;
      end
   end

   assign step = step_q;
   assign w    = w_q;
   assign pos  = pos_q;
   assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_l6_step_ctrl.sv
module tb_l6_step_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_n;
   logic       run;
   logic [7:0] rate;
   logic       load;
   logic [7:0] pattern;
   logic       w_in;
   logic       step;
   logic       w;
   logic [3:0] pos;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   l6_step_ctrl #(
      .DEB_CYCLES (4),
      .RATE_W     (8),
      .PAT_W      (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .key_n   (key_n),
      .run     (run),
      .rate    (rate),
      .load    (load),
      .pattern (pattern),
      .w_in    (w_in),
      .step    (step),
      .w       (w),
      .pos     (pos),
      .done    (done)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int         cnt;
      int         bad;
      int         first;
      logic [7:0] exp_pat;

      rst = 1'b0; key_n = 1'b1; run = 1'b0; rate = 8'd0;
      load = 1'b0; pattern = 8'd0; w_in = 1'b0;

      // reset held with key toggling
      repeat (6) begin
         cyc();
         key_n = ~key_n;
      end
      check_val("rst_step", step, 0);
      check_val("rst_w", w, 0);
      check_val("rst_pos", pos, 0);
      check_val("rst_done", done, 0);
      key_n = 1'b1;
      cyc();
      rst = 1'b1;

      cnt = 0;
      repeat (100) begin
         cyc();
         if (step) cnt++;
      end
      check_val("idle_steps", cnt, 0);

      // 3-cycle glitch
      key_n = 1'b0;
      cnt = 0;
      for (int i = 0; i < 23; i++) begin
         cyc();
         if (step) cnt++;
         if (i == 2) key_n = 1'b1;
      end
      check_val("glitch_steps", cnt, 0);

      // clean press, 20 cycles held; first sampling edge is i=1
      w_in = 1'b1;
      key_n = 1'b0;
      cnt = 0;
      first = -1;
      for (int i = 1; i <= 60; i++) begin
         cyc();
         if (step) begin
            cnt++;
            if (first < 0) begin
               first = i;
               check_val("press_w", w, 1);
            end
         end
         if (i == 20) key_n = 1'b1;
      end
      check_val("press_steps", cnt, 1);
      check_val("press_latency_edge", first, 8);

      // auto run, rate=9, with a key press during the run
      w_in = 1'b0;
      run  = 1'b1;
      rate = 8'd9;
      cnt = 0;
      bad = 0;
      for (int i = 1; i <= 60; i++) begin
         cyc();
         if (i == 5)  key_n = 1'b0;
         if (i == 25) key_n = 1'b1;
         if (step) begin
            cnt++;
            if (i % 10 != 0) bad++;
         end
      end
      check_val("auto_steps", cnt, 6);
      check_val("auto_misplaced", bad, 0);
      run = 1'b0;
      cnt = 0;
      repeat (30) begin
         cyc();
         if (step) cnt++;
      end
      check_val("auto_stop_steps", cnt, 0);

      // playback 8'b1111_0000 at rate 0
      pattern = 8'hF0;
      load = 1'b1;
      run  = 1'b1;
      rate = 8'd0;
      cyc();
      load = 1'b0;
      check_val("load_no_step", step, 0);
      check_val("load_pos", pos, 0);
      check_val("load_done", done, 0);
      exp_pat = 8'hF0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         check_val("play_step", step, 1);
         check_val("play_w", w, exp_pat[k]);
      end
      check_val("play_pos_end", pos, 8);
      check_val("play_done", done, 1);
      cnt = 0;
      repeat (5) begin
         cyc();
         if (step) cnt++;
      end
      check_val("done_no_steps", cnt, 0);
      check_val("done_pos_hold", pos, 8);

      // press in S_DONE returns to idle without stepping
      run = 1'b0;
      key_n = 1'b0;
      cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (step) cnt++;
         if (i == 3) check_val("done_before_press", done, 1);
      end
      check_val("done_press_steps", cnt, 0);
      check_val("done_after_press", done, 0);
      key_n = 1'b1;
      repeat (20) cyc();

      // load 8'hAA, play 3 bits, reload 8'h03 coincident with tick
      pattern = 8'hAA;
      load = 1'b1;
      run  = 1'b1;
      cyc();
      load = 1'b0;
      check_val("load2_no_step", step, 0);
      exp_pat = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check_val("aa_step", step, 1);
         check_val("aa_w", w, exp_pat[k]);
      end
      pattern = 8'h03;
      load = 1'b1;
      cyc();
      load = 1'b0;
      check_val("reload_no_step", step, 0);
      check_val("reload_pos", pos, 0);
      exp_pat = 8'h03;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check_val("p03_step", step, 1);
         check_val("p03_w", w, exp_pat[k]);
      end
      check_val("p03_pos", pos, 3);

      // asynchronous reset mid-playback
      rst = 1'b0;
      #2;
      check_val("mid_rst_pos", pos, 0);
      check_val("mid_rst_step", step, 0);
      check_val("mid_rst_done", done, 0);
      w_in = 1'b1;
      #1;
      rst = 1'b1;
      cnt = 0;
      repeat (4) begin
         cyc();
         if (step && w) cnt++;
      end
      check_val("post_rst_live_steps", cnt, 4);
      check_val("post_rst_pos", pos, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
